// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator. A pixel-rate tick (pix_en) advances a two-level
//   wrap-around counter pair (h, v). Sync, active-video, pixel coordinates and
//   line/frame pulses are decoded from the next counter values and registered,
//   so every output lines up with h_count/v_count in the same cycle.
//
//   Optional feature: define VGA_FRAME_COUNT_EN to build an 8-bit counter of
//   completed frames on frame_count. Without it, frame_count is tied to zero.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   pix_en       in   pixel tick; counters advance only when high
//   h_count      out  horizontal position, 0..H_TOTAL-1
//   v_count      out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL (line-based)
//   active       out  high inside the visible area
//   x, y         out  pixel coordinates inside the visible area, else 0
//   line_start   out  one-clk pulse when h wraps to 0
//   frame_start  out  one-clk pulse when (h, v) wraps to (0, 0)
//   frame_count  out  completed frames, mod 256 (optional feature)
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW        = $clog2(H_TOTAL),
  localparam int  VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  // Wrap points use exact equality, so counters never reach the totals.
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Window bounds are one bit wider than the counters: the sync end may
  // equal the total when the back porch is zero.
  localparam logic [HW:0] H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_START  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_START  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d, x_q, x_d;
  logic [VW-1:0] v_q, v_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;

  // Next counter values and decode of those values.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d          = '0;
        line_start_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    h_ext    = {1'b0, h_d};
    v_ext    = {1'b0, v_d};
    active_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    x_d      = active_d ? h_d : '0;
    y_d      = active_d ? v_d : '0;
    hsync_d  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  // Counter and decode registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  // Advances on the same edge that raises frame_start; wraps 255 -> 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_count_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the display path; consumes a pixel-rate tick and produces the horizontal/vertical counters, sync pulses, active-video flag and pixel coordinates.
- Downstream pixel/framebuffer fetch logic consumes its outputs.
- Replaces free-running generic counters with a two-level wrap-around counter pair and registered decode.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels), must be >= 1
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines), must be >= 1
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)
Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
pix_en  in  1  pixel tick; counters advance only on clk edges where pix_en=1
h_count  out  HW  horizontal position, 0..H_TOTAL-1
v_count  out  VW  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
active  out  1  1 when h_count < H_ACTIVE and v_count < V_ACTIVE
x  out  HW  h_count when active, else 0
y  out  VW  v_count when active, else 0
line_start  out  1  one-clk pulse when h_count wraps to 0
frame_start  out  1  one-clk pulse when (h_count, v_count) wraps to (0,0)
frame_count  out  8  frames completed (optional feature)

Behaviour:
- All outputs are registers. No combinational path from pix_en to any output.
- Reset (rst=0 at a clk edge) sets:
  - h_count = 0, v_count = 0, x = 0, y = 0
  - active = 0, line_start = 0, frame_start = 0, frame_count = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
- Reset takes priority over pix_en. Reset mid-frame returns to (0,0) on the next edge and issues no frame_start or line_start.
- Edge with rst=1, pix_en=1:
  - h_next = (h_count == H_TOTAL-1) ? 0 : h_count+1
  - When h wraps: v_next = (v_count == V_TOTAL-1) ? 0 : v_count+1; otherwise v_next = v_count.
- Edge with rst=1, pix_en=0: h_next = h_count, v_next = v_count.
- Every edge with rst=1 loads the decode registers from (h_next, v_next), so decode is always aligned with the counters (zero latency relative to h_count/v_count):
  - active and x/y as defined in Ports.
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h_next < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v_next < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL. vsync is line-based and does not depend on h.
- Pulses and pix_en:
  - line_start = 1 only on an edge where pix_en=1 and h wrapped. frame_start additionally requires v wrapped.
  - Both pulses last exactly one clk regardless of pix_en duty.
  - frame_start implies line_start in the same cycle.
- First edge after reset release with pix_en=0: counters stay (0,0), active becomes 1, no pulses.
- Wrap-around compares use exact equality against H_TOTAL-1 / V_TOTAL-1. Counters never reach H_TOTAL or V_TOTAL.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 (mod 256, 255 -> 0) on every edge where frame_start is set. Cleared by reset.
- Undefined: frame_count tied to 8'd0, no counter logic is synthesized, and the port is still present.

Test Plan:
All scenarios use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), active-low syncs.
1. rst=0 for 5 clk with pix_en=1 -> h=0, v=0, hsync=1, vsync=1, active=0, line_start=0, frame_start=0 throughout.
2. Release rst, pix_en=1 constant -> h cycles 0..7 and wraps; hsync=0 exactly at h=5,6; active=1 for h=0..3 on v=0..2; line_start high at each h 7->0; v goes 0->1 on the same edge.
3. Continue 48 enabled clks from (0,0) -> return to (0,0) with frame_start and line_start high for one clk; vsync=0 for all of v=4; x/y = 0 outside active.
4. pix_en toggling 1,0,1,0 -> counters advance every other clk; frame period = 96 clk; frame_start width = 1 clk; outputs hold while pix_en=0.
5. Assert rst=0 at h=3, v=2 -> next edge h=0, v=0, active=0, syncs inactive, no frame_start/line_start; after release the sequence restarts as in scenario 2.
6. With VGA_FRAME_COUNT_EN, run 257 frames -> frame_count 1 after first wrap, 255 after 255 wraps, 0 after 256 wraps, 1 after 257; without the macro, frame_count = 0 throughout.
